// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned engine: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle on a shared accumulator.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   acc_lo_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic [WIDTH:0]     add_sum, rem_sh, sub_diff;
  logic               ge;

  // acc = {hi_part, lo_part}: multiplier / dividend enters from the bottom
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    rem_sh   = acc[2*WIDTH-1:WIDTH-1];
    sub_diff = rem_sh - {1'b0, opnd};
    ge       = (rem_sh >= {1'b0, opnd});
    acc_nxt  = acc;
    if (div_q) begin
      if (ge) acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else    acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_nxt = {add_sum, acc[WIDTH-1:1]};
      else        acc_nxt = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      acc   <= {{WIDTH{1'b0}}, acc_lo_i};
      opnd  <= opnd_i;
      cnt   <= '0;
      div_q <= div_i;
    end else if (step_i) begin
      acc   <= acc_nxt;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign acc_o  = acc;
  assign last_c = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with multi-cycle MULT/MULTU/DIV/DIVU and
// single-cycle MTHI/MTLO, start/busy handshake and flush.
module hilo_muldiv
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e state, state_nxt;

  logic               signed_op, div_op, md_op, accept;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic               load_c, step_c, wr_res_c, wr_hi_c, wr_lo_c;
  logic [2*WIDTH-1:0] acc, prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;
  logic               div_q, neg_q, rneg_q, dz_q;
  logic [WIDTH-1:0]   rs_q;
  logic               last_c;

  // Operand conditioning: signed ops run on magnitudes
  always_comb begin
    signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
    div_op    = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    md_op     = signed_op || (op_i == OP_MULTU) || (op_i == OP_DIVU);
    accept    = start_i && !flush_i;
    rs_mag    = (signed_op && rs_i[WIDTH-1]) ? -rs_i : rs_i;
    rt_mag    = (signed_op && rt_i[WIDTH-1]) ? -rt_i : rt_i;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_c),
    .step_i   (step_c),
    .div_i    (div_op),
    .acc_lo_i (div_op ? rs_mag : rt_mag),
    .opnd_i   (div_op ? rt_mag : rs_mag),
    .acc_o    (acc),
    .last_c   (last_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && md_op) state_nxt = CALC;
      CALC:    if (flush_i) state_nxt = IDLE;
               else if (last_c) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    wr_res_c = 1'b0;
    wr_hi_c  = 1'b0;
    wr_lo_c  = 1'b0;
    case (state)
      IDLE: begin
        load_c  = accept && md_op;
        wr_hi_c = accept && (op_i == OP_MTHI);
        wr_lo_c = accept && (op_i == OP_MTLO);
      end
      CALC:    step_c   = !flush_i;
      FINISH:  wr_res_c = !flush_i;
      default: ;
    endcase
  end

  // Sign fixup; divide-by-zero returns the raw dividend and all-ones
  always_comb begin
    prod   = neg_q ? -acc : acc;
    quot   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_q) begin
      res_hi = dz_q ? rs_q : rem;
      res_lo = dz_q ? {WIDTH{1'b1}} : quot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o   <= '0;
      lo_o   <= '0;
      done_o <= 1'b0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      rs_q   <= '0;
    end else begin
      done_o <= wr_res_c || wr_hi_c || wr_lo_c;
      if (load_c) begin
        div_q  <= div_op;
        neg_q  <= signed_op && (rs_i[WIDTH-1] ^ rt_i[WIDTH-1]);
        rneg_q <= signed_op && rs_i[WIDTH-1];
        dz_q   <= div_op && (rt_i == '0);
        rs_q   <= rs_i;
      end
      if (wr_hi_c) hi_o <= rs_i;
      if (wr_lo_c) lo_o <= rs_i;
      if (wr_res_c) begin
        hi_o <= res_hi;
        lo_o <= res_lo;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with hand-computed HI/LO results.
module tb_hilo_muldiv;
  import hilo_pkg::*;

  logic        clk, rst, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int vectors = 0;
  int miscompares = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .flush_i (flush_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a multi-cycle op, track busy length, held HI/LO and done pulses
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input bit poke);
    logic [31:0] prev_hi, prev_lo;
    int n, early_done;
    bit held;
    prev_hi = hi_o;
    prev_lo = lo_o;
    start_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt;
    tick();
    start_i = 1'b0;
    n = 0; early_done = 0; held = 1'b1;
    while (busy_o && n < 100) begin
      n++;
      if (hi_o !== prev_hi || lo_o !== prev_lo) held = 1'b0;
      if (done_o) early_done++;
      if (poke && n == 3) begin
        start_i = 1'b1; op_i = OP_MTHI; rs_i = 32'hDEAD_BEEF;
      end else if (poke && n == 4) begin
        start_i = 1'b0;
      end
      tick();
    end
    check({tag, " busy cycles"}, 64'(n), 64'd33);
    check({tag, " hold"}, 64'(held), 64'd1);
    check({tag, " early done"}, 64'(early_done), 64'd0);
    check({tag, " done"}, 64'(done_o), 64'd1);
    check({tag, " hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo_o), 64'(exp_lo));
    tick();
    check({tag, " done cleared"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = OP_NONE; rs_i = '0; rt_i = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);

    run_op("mult", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div min", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("divu zero", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b0);
    run_op("div zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);

    // MTHI then MTLO back to back
    start_i = 1'b1; op_i = OP_MTHI; rs_i = 32'h1234_5678;
    tick();
    check("mthi hi", 64'(hi_o), 64'h1234_5678);
    check("mthi lo", 64'(lo_o), 64'hFFFF_FFFF);
    check("mthi busy", 64'(busy_o), 64'd0);
    check("mthi done", 64'(done_o), 64'd1);
    op_i = OP_MTLO; rs_i = 32'h9ABC_DEF0;
    tick();
    start_i = 1'b0;
    check("mtlo lo", 64'(lo_o), 64'h9ABC_DEF0);
    check("mtlo hi", 64'(hi_o), 64'h1234_5678);
    check("mtlo busy", 64'(busy_o), 64'd0);
    check("mtlo done", 64'(done_o), 64'd1);
    tick();
    check("mtx done cleared", 64'(done_o), 64'd0);

    // Flush alongside start in IDLE: nothing executes
    start_i = 1'b1; flush_i = 1'b1; op_i = OP_MTHI; rs_i = 32'h5555_5555;
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    check("idle flush hi", 64'(hi_o), 64'h1234_5678);
    check("idle flush done", 64'(done_o), 64'd0);
    check("idle flush busy", 64'(busy_o), 64'd0);

    // MULT flushed in CALC cycle 10
    start_i = 1'b1; op_i = OP_MULT; rs_i = 32'd9; rt_i = 32'd9;
    tick();
    start_i = 1'b0;
    check("flush busy start", 64'(busy_o), 64'd1);
    for (int i = 0; i < 9; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush busy", 64'(busy_o), 64'd0);
    check("flush hi", 64'(hi_o), 64'h1234_5678);
    check("flush lo", 64'(lo_o), 64'h9ABC_DEF0);
    check("flush done", 64'(done_o), 64'd0);
    tick();
    check("flush done later", 64'(done_o), 64'd0);

    // Reset at CALC cycle 5
    start_i = 1'b1; op_i = OP_MULT; rs_i = 32'd3; rt_i = 32'd3;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rst busy before", 64'(busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst hi", 64'(hi_o), 64'd0);
    check("rst lo", 64'(lo_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst done", 64'(done_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
